// File: rtl/uart_rx_data_reg_pkg.sv
// Shared types and constants for the UART receive data register block.
package uart_rx_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  // STATUS register bit positions
  localparam int unsigned STAT_RXV  = 0;
  localparam int unsigned STAT_OVR  = 1;
  localparam int unsigned STAT_FERR = 2;
  localparam int unsigned STAT_BUSY = 3;

  // CONTROL register bit positions (irq build only)
  localparam int unsigned CTRL_RXV_IE = 0;
  localparam int unsigned CTRL_ERR_IE = 1;

endpackage

// File: rtl/uart_rx_data_reg_if.sv
// Avalon-MM slave bus bundle for the UART receive data register.
interface uart_rx_data_reg_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/uart_rx_data_reg_core.sv
// 8N1 receive engine: input synchroniser, baud counter, FSM and shift
// register. Emits a one-cycle byte_strobe_o with the byte and stop-bit status.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_i,
  output logic                 byte_strobe_o,
  output logic [DATA_BITS-1:0] byte_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int unsigned BIT_W     = $clog2(DATA_BITS);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  logic                   rx_s;
  logic                   rx_fall;

  rx_state_e              state_q, state_d;
  logic [15:0]            baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  // An edge (not a level) starts a frame, so a line stuck low stays idle.
  assign rx_fall = rx_prev_q & ~rx_s;

  // Synchroniser chain and edge-detect history, idle-high on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q <= rx_s;
    end
  end

  // FSM state, counters and shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state, bit sampling and byte strobe generation
  always_comb begin
    state_d       = state_q;
    baud_d        = baud_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    byte_strobe_o = 1'b0;
    frame_err_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (rx_fall) state_d = ST_START;
      end
      ST_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d         = '0;
          shift_d[bit_q] = rx_s;
          if (bit_q == LAST_BIT) state_d = ST_STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d        = '0;
          byte_strobe_o = 1'b1;
          frame_err_o   = ~rx_s;
          state_d       = ST_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign byte_o = shift_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_rx_data_reg.sv
// UART receive data register: Avalon-MM register shell around uart_rx_core.
// Holds DATA/STATUS, commit/overrun handling and W1C error flags.
// Define UART_RX_IRQ_EN to add the CONTROL register and registered irq output.
module uart_rx_data_reg
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                reset,
  uart_rx_data_reg_if.slave   bus,
  input  logic                rx_in
`ifdef UART_RX_IRQ_EN
  ,
  output logic                irq
`endif
);

  logic                 byte_strobe;
  logic [DATA_BITS-1:0] rx_byte;
  logic                 frame_err;
  logic                 rx_busy;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 ferr_q, ferr_d;

  logic                 data_rd;
  logic                 status_wr;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_core (
    .clk           (clk),
    .reset         (reset),
    .rx_i          (rx_in),
    .byte_strobe_o (byte_strobe),
    .byte_o        (rx_byte),
    .frame_err_o   (frame_err),
    .busy_o        (rx_busy)
  );

  assign data_rd   = bus.chipselect & ~bus.read_n  & (bus.address == ADDR_DATA);
  assign status_wr = bus.chipselect & ~bus.write_n & (bus.address == ADDR_STATUS);

  // Commit, overrun and error flag update; a set event overrides a W1C clear
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    ferr_d     = ferr_q;

    if (data_rd) rx_valid_d = 1'b0;
    if (status_wr && bus.writedata[STAT_OVR])  overrun_d = 1'b0;
    if (status_wr && bus.writedata[STAT_FERR]) ferr_d    = 1'b0;

    if (byte_strobe) begin
      // A same-cycle DATA read frees the holding register for the new byte.
      if (!rx_valid_q || data_rd) rx_data_d = rx_byte;
      else                        overrun_d = 1'b1;
      rx_valid_d = 1'b1;
      if (frame_err) ferr_d = 1'b1;
    end
  end

  // Register shell state
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
    end
  end

`ifdef UART_RX_IRQ_EN
  logic [1:0] ctrl_q, ctrl_d;
  logic       irq_q, irq_d;
  logic       ctrl_wr;
  logic       wr_unused;

  assign ctrl_wr   = bus.chipselect & ~bus.write_n & (bus.address == ADDR_CTRL);
  assign wr_unused = ^bus.writedata[31:3];

  // Interrupt enables and registered interrupt request
  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_wr) ctrl_d = bus.writedata[1:0];
    irq_d = (rx_valid_q & ctrl_q[CTRL_RXV_IE]) |
            ((overrun_q | ferr_q) & ctrl_q[CTRL_ERR_IE]);
  end

  // CONTROL and irq registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic wr_unused;
  assign wr_unused = ^{bus.writedata[31:3], bus.writedata[0]};
`endif

  // Combinational read mux, zero wait states
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA: bus.readdata[DATA_BITS-1:0] = rx_data_q;
      ADDR_STATUS: begin
        bus.readdata[STAT_RXV]  = rx_valid_q;
        bus.readdata[STAT_OVR]  = overrun_q;
        bus.readdata[STAT_FERR] = ferr_q;
        bus.readdata[STAT_BUSY] = rx_busy;
      end
`ifdef UART_RX_IRQ_EN
      ADDR_CTRL: bus.readdata[1:0] = ctrl_q;
`endif
      default: bus.readdata = '0;
    endcase
  end

endmodule
